imem_resp: RTL and testbench

IMEM_RESP -- requirements
Module: imem_resp

---
 rtl/imem_resp_if.sv | 26 ++
 rtl/imem_resp.sv | 127 ++++++++++++
 tb/tb_imem_resp.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_resp_if.sv
// Fetch request/response bundle between the fetch unit and the instruction memory.
// Ports: master = fetch unit (drives req/flush/stall), slave = imem_resp (drives rdy/resp).
// Handshake: req accepted on req_v_i && req_rdy_o; resp held while stall_i is high.
interface imem_resp_if #(
  parameter int ADDR = 32,
  parameter int INST = 32
) ();
  logic            req_v_i;
  logic [ADDR-1:0] req_addr_i;
  logic            req_rdy_o;
  logic            flush_i;
  logic            stall_i;
  logic            resp_v_o;
  logic [ADDR-1:0] resp_addr_o;
  logic [INST-1:0] resp_inst_o;

  modport master (
    output req_v_i, req_addr_i, flush_i, stall_i,
    input  req_rdy_o, resp_v_o, resp_addr_o, resp_inst_o
  );

  modport slave (
    input  req_v_i, req_addr_i, flush_i, stall_i,
    output req_rdy_o, resp_v_o, resp_addr_o, resp_inst_o
  );
endinterface

// File: rtl/imem_resp.sv
// Instruction memory with registered read stage (S1) feeding a 2-entry response FIFO (S2).
// Latency: 2 cycles accept-to-response with an empty FIFO; loader writes are read-first.
// Backpressure: req_rdy_o from registered occupancy only; stall_i holds the head response.
// Ports: clk, rst (sync, active-high), bus (imem_resp_if.slave), ld_we_i/ld_addr_i/ld_data_i
// loader write port, err_o (only with IMEM_BOUNDS_CHK_EN: out-of-range fetch returns NOP).
// ADDR defaults to the project-wide 32-bit fetch word-address width.
module imem_resp #(
  parameter int ADDR    = 32,
  parameter int INST    = 32,
  parameter int IMEM_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  imem_resp_if.slave         bus,
  input  logic               ld_we_i,
  input  logic [IMEM_AW-1:0] ld_addr_i,
  input  logic [INST-1:0]    ld_data_i
`ifdef IMEM_BOUNDS_CHK_EN
  ,
  output logic               err_o
`endif
);
  localparam int IMEM_DEPTH = 2 ** IMEM_AW;

  logic [INST-1:0]    mem_q [IMEM_DEPTH];
  logic [IMEM_AW-1:0] rd_idx;
  logic               accept;
  logic               push;
  logic               pop;

  // S1: registered read result and its address
  logic               s1_v_q, s1_v_d;
  logic [ADDR-1:0]    s1_addr_q;
  logic [INST-1:0]    s1_inst_q;

  // S2: 2-entry response FIFO
  logic [1:0]         cnt_q, cnt_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [ADDR-1:0]    fifo_addr_q [2];
  logic [INST-1:0]    fifo_inst_q [2];

`ifdef IMEM_BOUNDS_CHK_EN
  localparam logic [INST-1:0] NOP = INST'(32'h0000_0013);
  logic               oob;
  logic               s1_err_q;
  logic               fifo_err_q [2];
  // Any set bit above the index range means the word lies beyond the memory.
  assign oob = |bus.req_addr_i[ADDR-1:IMEM_AW];
`endif

  assign rd_idx = bus.req_addr_i[IMEM_AW-1:0];

  // Slots in use counts S1 as well, so a word in flight always has a FIFO slot
  // waiting for it. Pops are deliberately not credited: keeps stall_i off this path.
  assign bus.req_rdy_o = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && !s1_v_q);
  assign accept        = bus.req_v_i && bus.req_rdy_o;

  // Flush kills the word leaving S1 and any pop of the head entry.
  assign push = s1_v_q && !bus.flush_i;
  assign pop  = bus.resp_v_o && !bus.stall_i && !bus.flush_i;

  always_comb begin
    // A request accepted in the flush cycle is younger than the redirect and survives.
    s1_v_d   = accept;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush_i) begin
      cnt_d    = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      s1_v_q   <= s1_v_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Loader port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_we_i) mem_q[ld_addr_i] <= ld_data_i;
  end

  // Datapath registers need no reset: every consumer is qualified by a valid bit.
  // The read samples mem_q before a same-edge loader write lands (read-first).
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_addr_q <= bus.req_addr_i;
`ifdef IMEM_BOUNDS_CHK_EN
      s1_inst_q <= oob ? NOP : mem_q[rd_idx];
      s1_err_q  <= oob;
`else
      s1_inst_q <= mem_q[rd_idx];
`endif
    end
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= s1_addr_q;
      fifo_inst_q[wr_ptr_q] <= s1_inst_q;
`ifdef IMEM_BOUNDS_CHK_EN
      fifo_err_q[wr_ptr_q]  <= s1_err_q;
`endif
    end
  end

  // Outputs are forced to zero when nothing is presented.
  assign bus.resp_v_o    = (cnt_q != 2'd0);
  assign bus.resp_addr_o = bus.resp_v_o ? fifo_addr_q[rd_ptr_q] : '0;
  assign bus.resp_inst_o = bus.resp_v_o ? fifo_inst_q[rd_ptr_q] : '0;
`ifdef IMEM_BOUNDS_CHK_EN
  assign err_o           = bus.resp_v_o ? fifo_err_q[rd_ptr_q] : 1'b0;
`endif
endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: reset, streaming, stall, flush, read-first loader, reset mid-run,
// and out-of-range fetch (NOP/err with IMEM_BOUNDS_CHK_EN, aliasing without).
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_imem_resp;
  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
`ifdef IMEM_BOUNDS_CHK_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  // Per-cycle observations captured by drive_stream
  logic        obs_v   [64];
  logic [31:0] obs_addr[64];
  logic [31:0] obs_inst[64];
  logic        obs_rdy [64];
  logic        obs_acc [64];
  logic [31:0] pop_addr[16];
  logic [31:0] pop_inst[16];
  int          n_pop;

  localparam logic [31:0] WORD_C = 32'hC0DE_0007;
  localparam logic [31:0] WORD_B = 32'hB0B0_0007;
  localparam logic [31:0] WORD_D = 32'hD00D_0006;

  always #5 clk = ~clk;

  imem_resp_if #(.ADDR(32), .INST(32)) bus ();

  imem_resp #(.ADDR(32), .INST(32), .IMEM_AW(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ld_we_i  (ld_we),
    .ld_addr_i(ld_addr),
    .ld_data_i(ld_data)
`ifdef IMEM_BOUNDS_CHK_EN
    ,
    .err_o    (err)
`endif
  );

  function automatic logic [31:0] a_word(input int i);
    return 32'hA0A0_0000 + 32'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = 10'(a);
    ld_data = d;
    step();
    ld_we   = 1'b0;
  endtask

  // Requests addresses 0..n_req-1 (each held until accepted), stall high for the
  // first n_stall cycles; records what the outputs showed in each cycle.
  task automatic drive_stream(input int n_req, input int ncyc, input int n_stall);
    int nxt = 0;
    n_pop = 0;
    for (int c = 0; c < ncyc; c++) begin
      bus.req_v_i    = (nxt < n_req);
      bus.req_addr_i = 32'(nxt);
      bus.stall_i    = (c < n_stall);
      #1;
      obs_v[c]    = bus.resp_v_o;
      obs_addr[c] = bus.resp_addr_o;
      obs_inst[c] = bus.resp_inst_o;
      obs_rdy[c]  = bus.req_rdy_o;
      obs_acc[c]  = bus.req_v_i && bus.req_rdy_o;
      if (bus.resp_v_o && !bus.stall_i && n_pop < 16) begin
        pop_addr[n_pop] = bus.resp_addr_o;
        pop_inst[n_pop] = bus.resp_inst_o;
        n_pop++;
      end
      if (obs_acc[c]) nxt++;
      @(posedge clk);
      #1;
    end
    bus.req_v_i = 1'b0;
    bus.stall_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush_i = 1'b1;
    bus.stall_i = 1'b1;
    step();
    step();
    checks++; if (bus.resp_v_o !== 1'b0) begin errors++; $display("FAIL reset_resp_v got %0b want 0", bus.resp_v_o); end
    checks++; if (bus.resp_addr_o !== 32'h0) begin errors++; $display("FAIL reset_resp_addr got %h want 0", bus.resp_addr_o); end
    checks++; if (bus.resp_inst_o !== 32'h0) begin errors++; $display("FAIL reset_resp_inst got %h want 0", bus.resp_inst_o); end
`ifdef IMEM_BOUNDS_CHK_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
`endif
    rst = 1'b0;
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    step();
    checks++; if (bus.req_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b want 1", bus.req_rdy_o); end
    checks++; if (bus.resp_v_o !== 1'b0) begin errors++; $display("FAIL post_reset_resp_v got %0b want 0", bus.resp_v_o); end
  endtask

  task automatic test_back_to_back();
    int fa = -1;
    int fr = -1;
    drive_stream(4, 20, 0);
    for (int c = 0; c < 20; c++) begin
      if (obs_acc[c] && fa < 0) fa = c;
      if (obs_v[c] && fr < 0) fr = c;
    end
    checks++; if (fa !== 0) begin errors++; $display("FAIL b2b_first_accept_cycle got %0d want 0", fa); end
    checks++; if (fr - fa !== 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", fr - fa); end
    checks++; if (n_pop !== 4) begin errors++; $display("FAIL b2b_resp_count got %0d want 4", n_pop); end
    for (int i = 0; i < 4 && i < n_pop; i++) begin
      checks++; if (pop_addr[i] !== 32'(i)) begin errors++; $display("FAIL b2b_addr[%0d] got %h want %h", i, pop_addr[i], 32'(i)); end
      checks++; if (pop_inst[i] !== a_word(i)) begin errors++; $display("FAIL b2b_inst[%0d] got %h want %h", i, pop_inst[i], a_word(i)); end
    end
    checks++; if (obs_v[19] !== 1'b0 || obs_addr[19] !== 32'h0 || obs_inst[19] !== 32'h0) begin
      errors++; $display("FAIL b2b_idle_zero got v=%0b addr=%h inst=%h want 0/0/0", obs_v[19], obs_addr[19], obs_inst[19]);
    end
  endtask

  task automatic test_stall();
    int acc_in_stall = 0;
    drive_stream(4, 30, 5);
    for (int c = 0; c < 5; c++) if (obs_acc[c]) acc_in_stall++;
    checks++; if (acc_in_stall !== 2) begin errors++; $display("FAIL stall_accepts got %0d want 2", acc_in_stall); end
    checks++; if (obs_rdy[4] !== 1'b0) begin errors++; $display("FAIL stall_rdy_low got %0b want 0", obs_rdy[4]); end
    for (int c = 2; c < 5; c++) begin
      checks++; if (obs_v[c] !== 1'b1 || obs_addr[c] !== 32'h0 || obs_inst[c] !== a_word(0)) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%0b addr=%h inst=%h want 1/0/%h", c, obs_v[c], obs_addr[c], obs_inst[c], a_word(0));
      end
    end
    checks++; if (n_pop !== 4) begin errors++; $display("FAIL stall_resp_count got %0d want 4", n_pop); end
    for (int i = 0; i < 4 && i < n_pop; i++) begin
      checks++; if (pop_addr[i] !== 32'(i) || pop_inst[i] !== a_word(i)) begin
        errors++; $display("FAIL stall_order[%0d] got addr=%h inst=%h want %h/%h", i, pop_addr[i], pop_inst[i], 32'(i), a_word(i));
      end
    end
  endtask

  task automatic test_flush();
    // Request accepted in the flush cycle survives; the older one in S1 does not.
    bus.req_v_i = 1'b1; bus.req_addr_i = 32'd4;
    step();
    bus.flush_i = 1'b1; bus.req_addr_i = 32'd2;
    ld_we = 1'b1; ld_addr = 10'd6; ld_data = WORD_D;
    checks++; if (bus.req_rdy_o !== 1'b1) begin errors++; $display("FAIL flushA_rdy got %0b want 1", bus.req_rdy_o); end
    step();
    bus.flush_i = 1'b0; bus.req_v_i = 1'b0; ld_we = 1'b0;
    checks++; if (bus.resp_v_o !== 1'b0) begin errors++; $display("FAIL flushA_no_stale got %0b want 0", bus.resp_v_o); end
    step();
    checks++; if (bus.resp_v_o !== 1'b1 || bus.resp_addr_o !== 32'd2 || bus.resp_inst_o !== a_word(2)) begin
      errors++; $display("FAIL flushA_resp got v=%0b addr=%h inst=%h want 1/2/%h", bus.resp_v_o, bus.resp_addr_o, bus.resp_inst_o, a_word(2));
    end
    step();
    // Accept 4 and 5, then flush while 4 sits in the FIFO and 5 in S1.
    bus.req_v_i = 1'b1; bus.req_addr_i = 32'd4;
    step();
    bus.req_addr_i = 32'd5;
    step();
    bus.flush_i = 1'b1; bus.req_addr_i = 32'd2;
    checks++; if (bus.req_rdy_o !== 1'b0) begin errors++; $display("FAIL flushB_rdy_preflush got %0b want 0", bus.req_rdy_o); end
    step();
    bus.flush_i = 1'b0;
    checks++; if (bus.resp_v_o !== 1'b0) begin errors++; $display("FAIL flushB_cleared got %0b want 0", bus.resp_v_o); end
    checks++; if (bus.req_rdy_o !== 1'b1) begin errors++; $display("FAIL flushB_rdy got %0b want 1", bus.req_rdy_o); end
    step();
    bus.req_v_i = 1'b0;
    checks++; if (bus.resp_v_o !== 1'b0) begin errors++; $display("FAIL flushB_no_5 got v=%0b addr=%h want 0", bus.resp_v_o, bus.resp_addr_o); end
    step();
    checks++; if (bus.resp_v_o !== 1'b1 || bus.resp_addr_o !== 32'd2 || bus.resp_inst_o !== a_word(2)) begin
      errors++; $display("FAIL flushB_resp got v=%0b addr=%h inst=%h want 1/2/%h", bus.resp_v_o, bus.resp_addr_o, bus.resp_inst_o, a_word(2));
    end
    step();
    checks++; if (bus.resp_v_o !== 1'b0) begin errors++; $display("FAIL flushB_drained got %0b want 0", bus.resp_v_o); end
    // Loader write issued during the flush cycle must have landed.
    bus.req_v_i = 1'b1; bus.req_addr_i = 32'd6;
    step();
    bus.req_v_i = 1'b0;
    step();
    checks++; if (bus.resp_inst_o !== WORD_D) begin errors++; $display("FAIL flush_loader got %h want %h", bus.resp_inst_o, WORD_D); end
    step();
  endtask

  task automatic test_read_first();
    ld_we = 1'b1; ld_addr = 10'd7; ld_data = WORD_B;
    bus.req_v_i = 1'b1; bus.req_addr_i = 32'd7;
    checks++; if (bus.req_rdy_o !== 1'b1) begin errors++; $display("FAIL rf_rdy got %0b want 1", bus.req_rdy_o); end
    step();
    ld_we = 1'b0; bus.req_v_i = 1'b0;
    step();
    checks++; if (bus.resp_v_o !== 1'b1 || bus.resp_addr_o !== 32'd7 || bus.resp_inst_o !== WORD_C) begin
      errors++; $display("FAIL rf_old got v=%0b addr=%h inst=%h want 1/7/%h", bus.resp_v_o, bus.resp_addr_o, bus.resp_inst_o, WORD_C);
    end
    step();
    bus.req_v_i = 1'b1; bus.req_addr_i = 32'd7;
    step();
    bus.req_v_i = 1'b0;
    step();
    checks++; if (bus.resp_inst_o !== WORD_B) begin errors++; $display("FAIL rf_new got %h want %h", bus.resp_inst_o, WORD_B); end
    step();
  endtask

  task automatic test_out_of_range();
    bus.stall_i = 1'b1;
    bus.req_v_i = 1'b1; bus.req_addr_i = 32'd1025;
    step();
    bus.req_v_i = 1'b0;
    step();
    for (int c = 0; c < 2; c++) begin
      checks++; if (bus.resp_v_o !== 1'b1 || bus.resp_addr_o !== 32'd1025) begin
        errors++; $display("FAIL oob_addr[%0d] got v=%0b addr=%h want 1/401", c, bus.resp_v_o, bus.resp_addr_o);
      end
`ifdef IMEM_BOUNDS_CHK_EN
      checks++; if (bus.resp_inst_o !== 32'h0000_0013) begin errors++; $display("FAIL oob_nop[%0d] got %h want 00000013", c, bus.resp_inst_o); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_err[%0d] got %0b want 1", c, err); end
`else
      checks++; if (bus.resp_inst_o !== a_word(1)) begin errors++; $display("FAIL oob_alias[%0d] got %h want %h", c, bus.resp_inst_o, a_word(1)); end
`endif
      step();
    end
    bus.stall_i = 1'b0;
    step();
    checks++; if (bus.resp_v_o !== 1'b0) begin errors++; $display("FAIL oob_drained got %0b want 0", bus.resp_v_o); end
`ifdef IMEM_BOUNDS_CHK_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL oob_err_clear got %0b want 0", err); end
`endif
  endtask

  task automatic test_reset_midrun();
    bus.stall_i = 1'b1;
    bus.req_v_i = 1'b1; bus.req_addr_i = 32'd0;
    step();
    bus.req_addr_i = 32'd1;
    step();
    bus.req_v_i = 1'b0;
    step();
    checks++; if (bus.resp_v_o !== 1'b1 || bus.req_rdy_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_buffered got v=%0b rdy=%0b want 1/0", bus.resp_v_o, bus.req_rdy_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.resp_v_o !== 1'b0 || bus.resp_addr_o !== 32'h0 || bus.resp_inst_o !== 32'h0) begin
      errors++; $display("FAIL rst_mid_cleared got v=%0b addr=%h inst=%h want 0/0/0", bus.resp_v_o, bus.resp_addr_o, bus.resp_inst_o);
    end
    checks++; if (bus.req_rdy_o !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy got %0b want 1", bus.req_rdy_o); end
    bus.stall_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.resp_v_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stale[%0d] got %0b want 0", c, bus.resp_v_o); end
    end
  endtask

  initial begin
    rst = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    bus.req_v_i = 1'b0; bus.req_addr_i = '0;
    bus.flush_i = 1'b0; bus.stall_i = 1'b0;
    test_reset();
    for (int i = 0; i < 6; i++) load(i, a_word(i));
    load(7, WORD_C);
    test_back_to_back();
    test_stall();
    test_flush();
    test_read_first();
    test_out_of_range();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
